fifo_byte_serializer: RTL and testbench
=======================================

Name: fifo_byte_serializer

Overview:
- Downstream drain stage for the 32-bit word FIFO. Pops words through the FIFO's rd/empty interface and emits them as a byte stream on a valid/ready handshake, one byte per cycle when sustained.
- Sits between the word FIFO and byte-wide consumers such as a UART TX or SPI shifter.
- Holds one prefetched word, so the FIFO's 1-cycle registered read latency causes no bubbles.

Parameters:
- DATA_W, 32, FIFO word width; must be a multiple of 8.
- MSB_FIRST, 1, 1 = byte [DATA_W-1:DATA_W-8] sent first; 0 = byte [7:0] sent first.
- CNT_W, 16, width of the completed-word counter.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous, active-low reset (sampled on the clk rising edge, asserted when 0).
- en  in  1  1 = pops allowed; 0 = no new pops, but words already fetched still drain.
- fifo_empty  in  1  FIFO empty flag.
- fifo_rd  out  1  FIFO read strobe.
- fifo_data  in  DATA_W  FIFO data_out; valid the cycle after fifo_rd.
- byte_out  out  8  current byte.
- byte_valid  out  1  byte_out is valid.
- byte_ready  in  1  consumer accepts when byte_valid && byte_ready.
- byte_last  out  1  high with the final byte of each word.
- busy  out  1  high when any word is active, held, or in flight.
- words_done  out  CNT_W  count of fully transmitted words; wraps modulo 2^CNT_W.

Behaviour:
- Reset (rst==0 at a clk edge) sets: fifo_rd=0, byte_valid=0, byte_out=0, byte_last=0, busy=0, words_done=0, rd_inflight=0, hold_valid=0, byte_idx=0, state=IDLE.
- Reset mid-word: the partial word is discarded. A read in flight is discarded, so that FIFO word is lost; this is accepted behaviour.
- Storage:
  - rd_inflight flag.
  - hold register plus hold_valid.
  - active shift register.
  - byte_idx counter, 0..DATA_W/8-1.
- fifo_rd = en && !fifo_empty && !hold_valid && !rd_inflight, with rst high.
  - Combinational from registered state and fifo_empty.
  - Never asserted on consecutive cycles, which rules out double pops against the FIFO's lagging empty flag.
- Cycle after fifo_rd: rd_inflight=1, and fifo_data is captured into hold (hold_valid=1). rd_inflight clears the same cycle.
- FSM states:
  - IDLE: byte_valid=0. If hold_valid, then next cycle active<=hold, hold_valid=0, byte_idx=0, go to SEND.
  - SEND: byte_valid=1. byte_out = active byte selected per MSB_FIRST and byte_idx. byte_last = (byte_idx==DATA_W/8-1).
- On a handshake in SEND:
  - Not last byte: byte_idx++.
  - Last byte: words_done++. If hold_valid (including a hold capture in the same cycle), active<=hold, byte_idx=0, stay in SEND. Otherwise go to IDLE.
- byte_ready low in SEND: byte_out, byte_valid, byte_last held stable. The prefetch still proceeds.
- Latency:
  - fifo_rd at cycle N gives byte_valid at N+2 from IDLE.
  - With byte_ready=1 and the FIFO non-empty, output is continuous at 1 byte/cycle, with no gap between words.
- en low: no new fifo_rd. The active word, held word and in-flight word still complete.
- busy = (state==SEND) || hold_valid || rd_inflight.
- fifo_empty rising while rd_inflight: no effect; the in-flight data is still captured.

Decomposition:
- Shared package fifo_pkg:
  - DATA_W default.
  - BYTES_PER_WORD = DATA_W/8.
  - State enum {IDLE, SEND}.
  - Byte-select function, parameterised by MSB_FIRST.
- One natural sub-module: fifo_prefetch_slot, which owns rd_inflight, hold and hold_valid, and generates fifo_rd.
- The top level keeps the FSM, the shifter and the counter.

Test Plan:
- Reset then idle: rst=0 for 2 cycles with fifo_empty=1 → all outputs 0, fifo_rd never asserted.
- Single word, MSB_FIRST=1: FIFO holds 32'hA1B2C3D4, byte_ready=1 → fifo_rd at N, then bytes A1,B2,C3,D4 on N+2..N+5, byte_last only with D4, words_done=1, busy=0 by N+6.
- Back-to-back: 3 words queued, byte_ready=1 → 12 consecutive byte_valid cycles with no gap, exactly 3 fifo_rd pulses, words_done=3.
- Backpressure: byte_ready toggles 1,0,0,1,… on word 32'h11223344 → byte_out held stable while ready=0, order 11,22,33,44 preserved, only one pop issued while hold_valid=1.
- en low mid-word: 2 words queued, en drops after the first byte → both already-fetched words finish (8 bytes), no further fifo_rd while a third word is in the FIFO; en=1 resumes popping.
- Reset mid-operation: rst=0 during byte 2 of 32'hDEADBEEF with a read in flight → next cycle byte_valid=0, busy=0, words_done=0, and no stale byte appears after rst returns high.

Source files
------------

// File: rtl/fifo_byte_serializer_pkg.sv
// Shared types and helpers for the word-FIFO byte serializer.
// Byte lane ordering is resolved here so the top stays width-agnostic.
package fifo_pkg;

  localparam int DATA_W = 32;
  localparam int BYTES_PER_WORD = DATA_W / 8;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_e;

  // Maps the transmit index to the byte lane inside the word.
  function automatic int unsigned byte_lane(
    input int unsigned idx,
    input int unsigned nbytes,
    input bit          msb_first
  );
    return msb_first ? (nbytes - 1 - idx) : idx;
  endfunction

endpackage

// File: rtl/fifo_byte_serializer_if.sv
// FIFO read port plus byte-stream handshake for the serializer.
// master = serializer side, slave = FIFO/consumer side.
interface fifo_byte_serializer_if #(
  parameter int DATA_W = fifo_pkg::DATA_W
);

  logic              fifo_empty;
  logic              fifo_rd;
  logic [DATA_W-1:0] fifo_data;
  logic [7:0]        byte_out;
  logic              byte_valid;
  logic              byte_ready;
  logic              byte_last;

  modport master (
    input  fifo_empty,
    input  fifo_data,
    input  byte_ready,
    output fifo_rd,
    output byte_out,
    output byte_valid,
    output byte_last
  );

  modport slave (
    output fifo_empty,
    output fifo_data,
    output byte_ready,
    input  fifo_rd,
    input  byte_out,
    input  byte_valid,
    input  byte_last
  );

endinterface

// File: rtl/fifo_byte_serializer_prefetch_slot.sv
// One-word prefetch slot: issues FIFO pops and parks the returned word.
// A word still in flight is offered directly so IDLE can skip the hold stage.
module fifo_prefetch_slot #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en_i,
  input  logic              fifo_empty_i,
  input  logic [DATA_W-1:0] fifo_data_i,
  input  logic              take_i,
  output logic              fifo_rd_o,
  output logic              avail_o,
  output logic [DATA_W-1:0] word_o,
  output logic              hold_valid_o,
  output logic              rd_inflight_o
);

  logic              rd_inflight_q;
  logic              hold_valid_q;
  logic              hold_valid_d;
  logic [DATA_W-1:0] hold_q;
  logic [DATA_W-1:0] hold_d;

  // Gating on rd_inflight keeps pops one cycle apart.
  assign fifo_rd_o = rst && en_i && !fifo_empty_i
                   && !hold_valid_q && !rd_inflight_q;

  assign avail_o = hold_valid_q || rd_inflight_q;
  assign word_o  = hold_valid_q ? hold_q : fifo_data_i;

  assign hold_valid_o  = hold_valid_q;
  assign rd_inflight_o = rd_inflight_q;

  always_comb begin
    hold_valid_d = hold_valid_q;
    hold_d       = hold_q;
    if (rd_inflight_q) begin
      hold_d       = fifo_data_i;
      hold_valid_d = 1'b1;
    end
    if (take_i) begin
      hold_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      rd_inflight_q <= 1'b0;
      hold_valid_q  <= 1'b0;
      hold_q        <= '0;
    end else begin
      rd_inflight_q <= fifo_rd_o;
      hold_valid_q  <= hold_valid_d;
      hold_q        <= hold_d;
    end
  end

endmodule

// File: rtl/fifo_byte_serializer.sv
// Drains 32-bit FIFO words as a valid/ready byte stream.
// Holds one prefetched word so sustained output runs at 1 byte/cycle.
module fifo_byte_serializer #(
  parameter int DATA_W    = fifo_pkg::DATA_W,
  parameter bit MSB_FIRST = 1'b1,
  parameter int CNT_W     = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   en,
  fifo_byte_serializer_if.master bus,
  output logic                   busy,
  output logic [CNT_W-1:0]       words_done
);

  import fifo_pkg::*;

  localparam int BPW   = DATA_W / 8;
  localparam int IDX_W = (BPW > 1) ? $clog2(BPW) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(BPW - 1);

  state_e            state_q;
  state_e            state_d;
  logic [IDX_W-1:0]  idx_q;
  logic [IDX_W-1:0]  idx_d;
  logic [DATA_W-1:0] active_q;
  logic [DATA_W-1:0] active_d;
  logic [CNT_W-1:0]  cnt_q;
  logic [CNT_W-1:0]  cnt_d;

  logic              take;
  logic              avail;
  logic              hold_valid;
  logic              rd_inflight;
  logic              hs;
  logic              is_last;
  logic [DATA_W-1:0] slot_word;
  logic [IDX_W-1:0]  lane;
  logic [7:0]        lanes [BPW];

  fifo_prefetch_slot #(
    .DATA_W (DATA_W)
  ) u_slot (
    .clk           (clk),
    .rst           (rst),
    .en_i          (en),
    .fifo_empty_i  (bus.fifo_empty),
    .fifo_data_i   (bus.fifo_data),
    .take_i        (take),
    .fifo_rd_o     (bus.fifo_rd),
    .avail_o       (avail),
    .word_o        (slot_word),
    .hold_valid_o  (hold_valid),
    .rd_inflight_o (rd_inflight)
  );

  assign hs      = (state_q == SEND) && bus.byte_ready;
  assign is_last = (idx_q == IDX_LAST);

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    active_d = active_q;
    cnt_d    = cnt_q;
    take     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (avail) begin
          take     = 1'b1;
          active_d = slot_word;
          idx_d    = '0;
          state_d  = SEND;
        end
      end
      SEND: begin
        if (hs) begin
          if (!is_last) begin
            idx_d = idx_q + IDX_W'(1);
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
            idx_d = '0;
            // Chain straight into the next word to avoid a bubble.
            if (avail) begin
              take     = 1'b1;
              active_d = slot_word;
            end else begin
              state_d = IDLE;
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= IDLE;
      idx_q    <= '0;
      active_q <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      active_q <= active_d;
      cnt_q    <= cnt_d;
    end
  end

  for (genvar g = 0; g < BPW; g++) begin : g_lane
    assign lanes[g] = active_q[8*g +: 8];
  end

  always_comb begin
    lane = IDX_W'(byte_lane(32'(idx_q), 32'(BPW), MSB_FIRST));
    bus.byte_out = 8'h00;
    if (state_q == SEND) begin
      bus.byte_out = lanes[lane];
    end
  end

  assign bus.byte_valid = (state_q == SEND);
  assign bus.byte_last  = (state_q == SEND) && is_last;

  assign busy       = (state_q == SEND) || hold_valid || rd_inflight;
  assign words_done = cnt_q;

endmodule

// File: tb/tb_fifo_byte_serializer.sv
// Randomized bench: FIFO model, byte scoreboard and directed scenarios.
// Expected bytes come from popped words split MSB-first.
module tb_fifo_byte_serializer;

  localparam int DW = 32;
  localparam int NB = DW / 8;
  localparam int CW = 16;

  typedef struct {
    logic [7:0] b;
    logic       l;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          en  = 1'b0;
  logic          busy;
  logic [CW-1:0] words_done;

  logic          push_en = 1'b0;
  logic [DW-1:0] push_w  = '0;

  logic [DW-1:0] fq [$];
  exp_t          exp_q [$];
  logic [7:0]    seen [$];
  logic [CW-1:0] exp_words = '0;

  int nvec = 0;
  int nbad = 0;
  int cyc = 0;
  int last_rd_cyc = 0;
  int rd_cnt = 0;
  int hs_cnt = 0;
  int span_first = 0;
  int span_last = 0;
  bit span_arm = 1'b0;

  logic       prev_v = 1'b0;
  logic       prev_r = 1'b0;
  logic       prev_l = 1'b0;
  logic       prev_rd = 1'b0;
  logic [7:0] prev_b = 8'h00;

  fifo_byte_serializer_if #(.DATA_W(DW)) bus ();

  fifo_byte_serializer #(
    .DATA_W    (DW),
    .MSB_FIRST (1'b1),
    .CNT_W     (CW)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .bus        (bus),
    .busy       (busy),
    .words_done (words_done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] want);
    nvec++;
    if (got !== want) begin
      nbad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)",
               tag, got, want, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [DW-1:0] w);
    push_en = 1'b1;
    push_w  = w;
    tick();
    push_en = 1'b0;
  endtask

  task automatic drain(input string tag, input int budget);
    int n = 0;
    while ((fq.size() != 0 || exp_q.size() != 0 || busy) && n < budget) begin
      tick();
      n++;
    end
    check({tag, "_timeout"}, 32'(n < budget), 32'd1);
  endtask

  task automatic wait_hs(input string tag, input int target, input int budget);
    int n = 0;
    while (hs_cnt < target && n < budget) begin
      tick();
      n++;
    end
    check({tag, "_timeout"}, 32'(n < budget), 32'd1);
  endtask

  // Registered-read FIFO model with registered empty flag.
  always @(posedge clk) begin
    if (bus.fifo_rd && fq.size() != 0) begin
      bus.fifo_data <= fq.pop_front();
    end
    if (push_en) begin
      fq.push_back(push_w);
    end
    bus.fifo_empty <= (fq.size() == 0);
  end

  // Scoreboard: every pop appends its bytes, every handshake consumes one.
  always @(negedge clk) begin
    cyc++;
    if (!rst) begin
      check("rd_in_reset", 32'(bus.fifo_rd), 32'd0);
      exp_q.delete();
      exp_words = '0;
      prev_v = 1'b0;
      prev_r = 1'b0;
      prev_rd = 1'b0;
    end else begin
      check("words_done", 32'(words_done), 32'(exp_words));
      check("busy", 32'(busy), 32'(exp_q.size() != 0));
      if (prev_v && !prev_r) begin
        check("stall_valid", 32'(bus.byte_valid), 32'd1);
        check("stall_byte", 32'(bus.byte_out), 32'(prev_b));
        check("stall_last", 32'(bus.byte_last), 32'(prev_l));
      end
      if (bus.byte_valid && !prev_v) begin
        check("latency", 32'(cyc - last_rd_cyc), 32'd2);
      end
      if (bus.fifo_rd) begin
        check("rd_gate", {29'd0, en, !bus.fifo_empty, !prev_rd}, 32'd7);
        if (fq.size() != 0) begin
          for (int i = 0; i < NB; i++) begin
            exp_t e;
            e.b = 8'(fq[0] >> (8 * (NB - 1 - i)));
            e.l = (i == NB - 1);
            exp_q.push_back(e);
          end
        end
        rd_cnt++;
        last_rd_cyc = cyc;
      end
      if (bus.byte_valid && bus.byte_ready) begin
        hs_cnt++;
        seen.push_back(bus.byte_out);
        if (span_arm) begin
          span_first = cyc;
          span_arm = 1'b0;
        end
        span_last = cyc;
        if (exp_q.size() == 0) begin
          check("stray_byte", {24'd0, bus.byte_out}, 32'hFFFF_FFFF);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check("byte", 32'(bus.byte_out), 32'(e.b));
          check("last", 32'(bus.byte_last), 32'(e.l));
          if (e.l) exp_words = exp_words + CW'(1);
        end
      end
      prev_v  = bus.byte_valid;
      prev_r  = bus.byte_ready;
      prev_b  = bus.byte_out;
      prev_l  = bus.byte_last;
      prev_rd = bus.fifo_rd;
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int rd0;
    int hs0;
    int n_rand;
    logic [DW-1:0] w;

    bus.byte_ready = 1'b0;
    rst = 1'b0;
    en  = 1'b0;
    repeat (2) tick();
    check("rst_valid", 32'(bus.byte_valid), 32'd0);
    check("rst_byte", 32'(bus.byte_out), 32'd0);
    check("rst_last", 32'(bus.byte_last), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_words", 32'(words_done), 32'd0);
    check("rst_rd", 32'(bus.fifo_rd), 32'd0);
    rst = 1'b1;
    tick();

    // Single word, MSB first.
    seen.delete();
    rd0 = rd_cnt;
    push(32'hA1B2C3D4);
    bus.byte_ready = 1'b1;
    en = 1'b1;
    drain("single", 50);
    check("single_cnt", 32'(seen.size()), 32'd4);
    check("single_word", {seen[0], seen[1], seen[2], seen[3]}, 32'hA1B2C3D4);
    check("single_done", 32'(words_done), 32'd1);
    check("single_pops", 32'(rd_cnt - rd0), 32'd1);

    // Back-to-back words: no gaps between words.
    en = 1'b0;
    rd0 = rd_cnt;
    hs0 = hs_cnt;
    for (int i = 0; i < 3; i++) push($urandom());
    span_arm = 1'b1;
    en = 1'b1;
    drain("b2b", 80);
    check("b2b_bytes", 32'(hs_cnt - hs0), 32'd12);
    check("b2b_span", 32'(span_last - span_first), 32'd11);
    check("b2b_pops", 32'(rd_cnt - rd0), 32'd3);
    check("b2b_done", 32'(words_done), 32'd4);

    // Backpressure pattern 1,0,0,1 with a second word prefetched.
    en = 1'b0;
    seen.delete();
    rd0 = rd_cnt;
    push(32'h11223344);
    push(32'h55667788);
    en = 1'b1;
    for (int i = 0; i < 200; i++) begin
      bus.byte_ready = (i % 4 == 0) || (i % 4 == 3);
      if (fq.size() == 0 && exp_q.size() == 0 && !busy) break;
      tick();
    end
    bus.byte_ready = 1'b1;
    drain("bp", 50);
    check("bp_order", {seen[0], seen[1], seen[2], seen[3]}, 32'h11223344);
    check("bp_order2", {seen[4], seen[5], seen[6], seen[7]}, 32'h55667788);
    check("bp_pops", 32'(rd_cnt - rd0), 32'd2);

    // en drops after the first byte: fetched words still finish.
    en = 1'b0;
    rd0 = rd_cnt;
    hs0 = hs_cnt;
    for (int i = 0; i < 3; i++) push($urandom());
    en = 1'b1;
    wait_hs("en_first", hs0 + 1, 40);
    en = 1'b0;
    repeat (30) tick();
    check("en_bytes", 32'(hs_cnt - hs0), 32'd8);
    check("en_pops", 32'(rd_cnt - rd0), 32'd2);
    check("en_left", 32'(fq.size()), 32'd1);
    check("en_busy", 32'(busy), 32'd0);
    en = 1'b1;
    drain("en_resume", 50);
    check("en_pops_all", 32'(rd_cnt - rd0), 32'd3);
    check("en_bytes_all", 32'(hs_cnt - hs0), 32'd12);

    // Reset during byte 2 with the next word in flight.
    en = 1'b0;
    hs0 = hs_cnt;
    push(32'hDEADBEEF);
    push(32'h0BADF00D);
    en = 1'b1;
    wait_hs("mid_first", hs0 + 1, 40);
    check("mid_inflight", 32'(fq.size()), 32'd0);
    rst = 1'b0;
    tick();
    rst = 1'b1;
    check("mid_valid", 32'(bus.byte_valid), 32'd0);
    check("mid_busy", 32'(busy), 32'd0);
    check("mid_words", 32'(words_done), 32'd0);
    for (int i = 0; i < 8; i++) begin
      tick();
      check("mid_quiet", 32'(bus.byte_valid), 32'd0);
    end

    // Random traffic, random ready and en.
    n_rand = 0;
    for (int i = 0; i < 600; i++) begin
      bus.byte_ready = ($urandom_range(0, 3) != 0);
      en = ($urandom_range(0, 7) != 0);
      w = $urandom();
      push_w = w;
      push_en = ($urandom_range(0, 2) == 0);
      if (push_en) n_rand++;
      tick();
    end
    push_en = 1'b0;
    en = 1'b1;
    bus.byte_ready = 1'b1;
    drain("rand", 2000);
    check("rand_done", 32'(words_done), 32'(n_rand));

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
    $finish;
  end

endmodule
